alu_arbiter: RTL

Round-robin scheduler sharing one multi-cycle 8-bit ALU (`alu_top2`, ops ADD/SUB/MUL, 16-bit result, 3-bit state with IDLE = 3'b000) between NREQ requesters. Accepts one request at a time and latches its operands. Drives the ALU `start`/`a`/`b`/`op` inputs, tracks the ALU state until the operation completes, then returns the 16-bit result to the granted requester with a one-cycle done pulse. Sits between requester blocks and the single ALU instance.

---
 rtl/alu_arbiter_if.sv | 33 +++
 rtl/alu_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if
//   Requester-side bus of the shared-ALU arbiter.
//   master : requester blocks (drive req/operands, receive gnt/done/result)
//   slave  : alu_arbiter
//   req         NREQ      per-requester request level
//   req_a/req_b NREQ*8    operands, requester i at [8i+7:8i]
//   req_op      NREQ*2    opcode, requester i at [2i+1:2i]
//   gnt         NREQ      one-hot pulse, operands accepted
//   done        NREQ      one-hot pulse, result valid
//   rsp_result  16        result of the last completed operation
//   err         1         timeout flag, valid with done
interface alu_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ*8-1:0] req_a;
   logic [NREQ*8-1:0] req_b;
   logic [NREQ*2-1:0] req_op;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [15:0]       rsp_result;
   logic              err;

   modport master (
      output req, req_a, req_b, req_op,
      input  gnt, done, rsp_result, err
   );

   modport slave (
      input  req, req_a, req_b, req_op,
      output gnt, done, rsp_result, err
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Round-robin scheduler sharing one multi-cycle 8-bit ALU between NREQ
//   requesters. One operation in flight at a time; operands are latched at
//   grant, the ALU state is tracked until it returns to IDLE, and the result
//   is handed back to the owner with a one-cycle done pulse.
//
//   Optional feature macro: ALU_ARB_TIMEOUT_EN
//     defined   : watchdog of TIMEOUT cycles from grant; on expiry done[owner]
//                 fires with err=1 and rsp_result=16'hFFFF
//     undefined : no watchdog, err stays 0, a stuck ALU keeps busy high
//
//   Ports
//     clk         clock, rising edge
//     rst         asynchronous active-low reset
//     rq          requester bus (alu_arbiter_if.slave)
//     busy        high while arb_state != IDLE
//     arb_state   IDLE=0, WAIT_BUSY=1, WAIT_DONE=2
//     alu_start   one-cycle start pulse to the ALU
//     alu_a/b/op  latched operands and opcode
//     alu_result  ALU result
//     alu_state   ALU state, 3'b000 = ALU idle
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no operation in flight, grant the next requester
//   WAIT_BUSY | start issued, waiting for the ALU to leave its idle state
//   WAIT_DONE | ALU running, waiting for it to return to idle
module alu_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave rq,
   output logic         busy,
   output logic [1:0]   arb_state,
   output logic         alu_start,
   output logic [7:0]   alu_a,
   output logic [7:0]   alu_b,
   output logic [1:0]   alu_op,
   input  logic [15:0]  alu_result,
   input  logic [2:0]   alu_state
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t          state;
   logic [PW-1:0]   ptr;
   logic [NREQ-1:0] owner;

   logic [PW-1:0]   pick;
   logic [PW-1:0]   idx;
   logic [PW-1:0]   ptr_nxt;
   logic [NREQ-1:0] pick_oh;
   logic            pick_vld;

   // Search downward from the farthest candidate so the requester closest to
   // the pointer is the last (winning) assignment.
   always_comb begin
      pick     = '0;
      idx      = '0;
      pick_oh  = '0;
      pick_vld = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (rq.req[idx]) begin
            pick          = idx;
            pick_oh       = '0;
            pick_oh[idx]  = 1'b1;
            pick_vld      = 1'b1;
         end
      end
   end

   assign ptr_nxt   = (pick == PW'(NREQ - 1)) ? '0 : pick + PW'(1);
   assign arb_state = state;

`ifdef ALU_ARB_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] tmo_cnt;
`else
   localparam int unused_timeout = TIMEOUT;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         ptr           <= '0;
         owner         <= '0;
         busy          <= 1'b0;
         alu_start     <= 1'b0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_op        <= '0;
         rq.gnt        <= '0;
         rq.done       <= '0;
         rq.rsp_result <= '0;
         rq.err        <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
         tmo_cnt       <= '0;
`endif
      end else begin
         rq.gnt    <= '0;
         rq.done   <= '0;
         alu_start <= 1'b0;

         unique case (state)
            IDLE: begin
               if (pick_vld) begin
                  rq.gnt    <= pick_oh;
                  alu_start <= 1'b1;
                  alu_a     <= rq.req_a[int'(pick)*8 +: 8];
                  alu_b     <= rq.req_b[int'(pick)*8 +: 8];
                  alu_op    <= rq.req_op[int'(pick)*2 +: 2];
                  owner     <= pick_oh;
                  ptr       <= ptr_nxt;
                  busy      <= 1'b1;
                  state     <= WAIT_BUSY;
`ifdef ALU_ARB_TIMEOUT_EN
                  // Expires on the TIMEOUT-th edge after the grant edge.
                  tmo_cnt   <= TW'(TIMEOUT - 1);
`endif
               end
            end
            WAIT_BUSY: begin
               if (alu_state != 3'b000) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (alu_state == 3'b000) begin
                  rq.done       <= owner;
                  rq.rsp_result <= alu_result;
                  rq.err        <= 1'b0;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase

`ifdef ALU_ARB_TIMEOUT_EN
         // A genuine completion on the expiry edge wins over the watchdog.
         if (state != IDLE && !(state == WAIT_DONE && alu_state == 3'b000)) begin
            if (tmo_cnt == '0) begin
               rq.done       <= owner;
               rq.rsp_result <= 16'hFFFF;
               rq.err        <= 1'b1;
               busy          <= 1'b0;
               state         <= IDLE;
            end else begin
               tmo_cnt <= tmo_cnt - TW'(1);
            end
         end
`endif
      end
   end
endmodule
